add_multiword_seq: RTL and testbench

Multi-cycle wide-operand adder controller. It accepts a WORD_NUM*DATA_WIDTH-bit add request over a valid/ready handshake and processes one DATA_WIDTH chunk per cycle, least significant chunk first. Each chunk is fed through one internal add_nnbit_ahead_serial instance, and the chunk carry is registered between cycles. It lets wide additions in the calc path reuse one narrow carry-lookahead adder instead of a full-width one.

---
 rtl/add_multiword_seq.sv | 161 ++++++++++++++++
 tb/tb_add_multiword_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_multiword_seq.sv
// Multi-cycle wide adder: one DATA_WIDTH chunk per cycle through one
// narrow carry-lookahead adder. Optional subtract: ADD_MULTIWORD_SEQ_SUB_EN.
//
// Ports: i_clk, i_rst (async, active-high); request i_valid/o_ready with
// i_num_a, i_num_b, i_cry (and i_sub when the macro is defined);
// result o_valid/i_ready with o_res, o_cry; o_busy while CALC or DONE.

module add_nnbit_ahead_serial #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cry,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_cry
);
  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [DATA_WIDTH:0]   c;

  always_comb begin
    g    = i_a & i_b;
    p    = i_a ^ i_b;
    c    = '0;
    c[0] = i_cry;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign o_sum = p ^ c[DATA_WIDTH-1:0];
  assign o_cry = c[DATA_WIDTH];
endmodule

module add_multiword_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_NUM   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WIDTH*WORD_NUM-1:0] i_num_a,
  input  logic [DATA_WIDTH*WORD_NUM-1:0] i_num_b,
  input  logic                           i_cry,
`ifdef ADD_MULTIWORD_SEQ_SUB_EN
  input  logic                           i_sub,
`endif
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH*WORD_NUM-1:0] o_res,
  output logic                           o_cry,
  output logic                           o_busy
);
  localparam int TW = DATA_WIDTH * WORD_NUM;
  localparam int IW = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic            c_q, c_d;
  logic [TW-1:0]   res_q, res_d;
  logic            ocry_q, ocry_d;

  logic [DATA_WIDTH-1:0] ch_a;
  logic [DATA_WIDTH-1:0] ch_b;
  logic [DATA_WIDTH-1:0] ch_sum;
  logic                  ch_cry;
  logic                  sub_w;
  logic                  last_w;

`ifdef ADD_MULTIWORD_SEQ_SUB_EN
  assign sub_w = i_sub;
`else
  assign sub_w = 1'b0;
`endif

  assign ch_a   = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign ch_b   = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign last_w = (idx_q == IW'(WORD_NUM-1));

  add_nnbit_ahead_serial #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_add (
    .i_a   (ch_a),
    .i_b   (ch_b),
    .i_cry (c_q),
    .o_sum (ch_sum),
    .o_cry (ch_cry)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    ocry_d  = ocry_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_num_a;
          // Subtract is A + ~B + 1; the +1 rides in on the chunk-0 carry.
          b_d     = sub_w ? ~i_num_b : i_num_b;
          c_d     = sub_w ? 1'b1 : i_cry;
          idx_d   = '0;
          res_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        res_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = ch_sum;
        c_d   = ch_cry;
        idx_d = idx_q + 1'b1;
        if (last_w) begin
          ocry_d  = ch_cry;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      ocry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      ocry_q  <= ocry_d;
    end
  end

  assign o_ready = (state_q == S_IDLE) & ~i_rst;
  assign o_valid = (state_q == S_DONE);
  assign o_busy  = (state_q != S_IDLE);
  assign o_res   = res_q;
  assign o_cry   = ocry_q;
endmodule

// File: tb/tb_add_multiword_seq.sv
// Testbench for add_multiword_seq: vector table, scoreboard queue and
// hand-written handshake/backpressure/reset sequences.

module tb_add_multiword_seq;
  localparam int DW = 8;
  localparam int WN = 4;
  localparam int TW = DW * WN;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [TW-1:0] i_num_a;
  logic [TW-1:0] i_num_b;
  logic          i_cry;
`ifdef ADD_MULTIWORD_SEQ_SUB_EN
  logic          i_sub;
`endif
  logic          o_valid;
  logic          i_ready;
  logic [TW-1:0] o_res;
  logic          o_cry;
  logic          o_busy;

  add_multiword_seq #(
    .DATA_WIDTH (DW),
    .WORD_NUM   (WN)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .i_cry   (i_cry),
`ifdef ADD_MULTIWORD_SEQ_SUB_EN
    .i_sub   (i_sub),
`endif
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_cry   (o_cry),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [TW-1:0] res;
    logic          cry;
  } exp_t;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW-1:0] res;
    logic          cry;
  } vec_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_sub(input logic s);
`ifdef ADD_MULTIWORD_SEQ_SUB_EN
    i_sub = s;
`else
    if (s) $display("note: subtract requested without subtract support");
`endif
  endtask

  task automatic scramble();
    i_num_a = $urandom;
    i_num_b = $urandom;
    i_cry   = 1'($urandom);
    set_sub(1'b0);
  endtask

  task automatic accept(input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic cin, input logic sub,
                        input logic [TW-1:0] er, input logic ec);
    chk("accept_ready", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_num_a = a;
    i_num_b = b;
    i_cry   = cin;
    set_sub(sub);
    q.push_back('{er, ec});
    step();
    i_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input string nm);
    int   n;
    exp_t e;
    n = 0;
    while (!o_valid && n < 20) begin
      chk({nm, "_ready_low"}, 64'(o_ready), 64'd0);
      step();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(WN));
    if (q.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(0), 64'(1));
    end else begin
      e = q.pop_front();
      chk({nm, "_res"}, 64'(o_res), 64'(e.res));
      chk({nm, "_cry"}, 64'(o_cry), 64'(e.cry));
    end
  endtask

  task automatic release_res(input string nm);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({nm, "_rel_valid"}, 64'(o_valid), 64'd0);
    chk({nm, "_rel_ready"}, 64'(o_ready), 64'd1);
    chk({nm, "_rel_busy"}, 64'(o_busy), 64'd0);
  endtask

  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW:0]   full;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rc;
    int            t0;
    int            t1;
    exp_t          e;

    tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[2] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 1'b0, 32'hE1E1E1E0, 1'b1};
    tbl[3] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    tbl[5] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_num_a = '0;
    i_num_b = '0;
    i_cry   = 1'b0;
    set_sub(1'b0);
    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_res", 64'(o_res), 64'd0);
    chk("rst_cry", 64'(o_cry), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(o_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, tbl[i].res, tbl[i].cry);
      wait_done($sformatf("vec%0d", i));
      release_res($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{TW{1'b0}}, rc};
      accept(ra, rb, rc, 1'b0, full[TW-1:0], full[TW]);
      wait_done($sformatf("rnd%0d", i));
      release_res($sformatf("rnd%0d", i));
    end

    // Back-to-back with consumer always ready.
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_num_a = tbl[2].a;
    i_num_b = tbl[2].b;
    i_cry   = tbl[2].cin;
    q.push_back('{tbl[2].res, tbl[2].cry});
    t0 = cyc + 1;
    step();
    i_num_a = tbl[3].a;
    i_num_b = tbl[3].b;
    i_cry   = tbl[3].cin;
    for (int n = 0; n < 20; n++) begin
      if (o_valid) begin
        e = q.pop_front();
        chk("b2b_res0", 64'(o_res), 64'(e.res));
        chk("b2b_cry0", 64'(o_cry), 64'(e.cry));
      end
      if (o_ready) break;
      step();
    end
    t1 = cyc + 1;
    chk("b2b_interval", 64'(t1 - t0), 64'(WN + 2));
    chk("b2b_q_drained", 64'(q.size()), 64'd0);
    q.push_back('{tbl[3].res, tbl[3].cry});
    step();
    i_valid = 1'b0;
    i_ready = 1'b0;
    scramble();
    wait_done("b2b1");
    release_res("b2b1");

    // Backpressure in DONE.
    accept(tbl[0].a, tbl[0].b, tbl[0].cin, 1'b0, tbl[0].res, tbl[0].cry);
    wait_done("bp");
    for (int n = 0; n < 5; n++) begin
      i_valid = ~i_valid;
      scramble();
      step();
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_res", 64'(o_res), 64'(tbl[0].res));
      chk("bp_cry", 64'(o_cry), 64'(tbl[0].cry));
      chk("bp_ready", 64'(o_ready), 64'd0);
    end
    i_valid = 1'b0;
    release_res("bp");

    // Reset two cycles into CALC, after a carry-heavy operand pair.
    accept(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1);
    step();
    step();
    #2;
    i_rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_res", 64'(o_res), 64'd0);
    chk("midrst_cry", 64'(o_cry), 64'd0);
    q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    accept(32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0);
    wait_done("postrst");
    release_res("postrst");

`ifdef ADD_MULTIWORD_SEQ_SUB_EN
    accept(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
    wait_done("sub0");
    release_res("sub0");
    accept(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1);
    wait_done("sub1");
    release_res("sub1");
    accept(32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h0000000D, 1'b0);
    wait_done("sub_off");
    release_res("sub_off");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
